// File: rtl/deconvol_if.sv
// Load/emit bus for the deconvolution block: beat stream in, recovered samples out.
interface deconvol_if;
  logic       in_valid;
  logic [7:0] Y;
  logic [7:0] B;
  logic [7:0] out;
  logic       out_valid;
  logic       done;
  logic       err;

  modport master (output in_valid, Y, B, input out, out_valid, done, err);
  modport slave  (input in_valid, Y, B, output out, out_valid, done, err);
endinterface

// File: rtl/deconvol.sv
// Sequential deconvolution: loads y[0..m+n-2] and b[0..n-1], recovers a[0..m-1]
// by back-substitution (n-1 multiply-subtract steps) and an 8-cycle restoring divide.
module deconvol #(
  parameter int m = 6,
  parameter int n = 5
) (
  input  logic    clk,
  input  logic    rst,
  deconvol_if.slave bus
);

  localparam int IW    = $clog2(m + n);
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] BEAT_LAST = IW'(m + n - 2);
  localparam logic [IW-1:0] K_LAST    = IW'(m - 1);
  localparam logic [IW-1:0] J_LAST    = IW'(n - 1);
  localparam logic [IW-1:0] J_FIRST   = IW'(1);
  localparam logic [IW-1:0] N_IDX     = IW'(n);

  typedef enum logic [2:0] {IDLE, LOAD, SOLVE, DIV, EMIT} state_t;

  state_t state, state_nxt;

  logic [IW-1:0] beat, k, j;
  logic [2:0]    dcnt;
  logic [7:0]    r, q, rem;
  logic [7:0]    y [DEPTH];
  logic [7:0]    b [DEPTH];
  logic [7:0]    a [DEPTH];

  logic [7:0]    r_cur, term, q_src, rem_src, q_nxt, rem_nxt;
  logic [8:0]    trial, diff;
  logic          accept;

  logic [7:0]    out_r, out_nxt;
  logic          ov_r, ov_nxt, done_r, done_nxt, err_r, err_nxt;

  assign accept = (state == IDLE || state == LOAD) && bus.in_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: if (bus.in_valid) state_nxt = (beat == BEAT_LAST) ? SOLVE : LOAD;
      SOLVE:      if (j == J_LAST) state_nxt = DIV;
      DIV:        if (dcnt == 3'd7) state_nxt = (k == K_LAST) ? EMIT : SOLVE;
      EMIT:       if (k == K_LAST) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Residue step and one restoring-divide step
  always_comb begin
    r_cur   = (j == J_FIRST) ? y[k] : r;
    term    = (k >= j) ? a[k - j] * b[j] : '0;
    q_src   = (dcnt == 3'd0) ? r : q;
    rem_src = (dcnt == 3'd0) ? '0 : rem;
    trial   = {rem_src, q_src[7]};
    diff    = trial - {1'b0, b[0]};
    if (trial >= {1'b0, b[0]}) begin
      rem_nxt = diff[7:0];
      q_nxt   = {q_src[6:0], 1'b1};
    end else begin
      rem_nxt = trial[7:0];
      q_nxt   = {q_src[6:0], 1'b0};
    end
  end

  // Counters and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
      k    <= '0;
      j    <= J_FIRST;
      dcnt <= '0;
      r    <= '0;
      q    <= '0;
      rem  <= '0;
    end else begin
      case (state)
        IDLE, LOAD: if (bus.in_valid) begin
          if (beat == BEAT_LAST) begin
            beat <= '0;
            k    <= '0;
            j    <= J_FIRST;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        SOLVE: begin
          r <= r_cur - term;
          if (j == J_LAST) begin
            j    <= J_FIRST;
            dcnt <= '0;
          end else begin
            j <= j + 1'b1;
          end
        end
        DIV: begin
          q    <= q_nxt;
          rem  <= rem_nxt;
          dcnt <= dcnt + 1'b1;
          if (dcnt == 3'd7) k <= (k == K_LAST) ? '0 : k + 1'b1;
        end
        EMIT: k <= (k == K_LAST) ? '0 : k + 1'b1;
        default: ;
      endcase
    end
  end

  // Sample storage: loaded beats and recovered samples (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      y[beat] <= bus.Y;
      if (beat < N_IDX) b[beat] <= bus.B;
    end
    if (state == DIV && dcnt == 3'd7) a[k] <= (b[0] == 8'h00) ? 8'hFF : q_nxt;
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    out_nxt  = out_r;
    ov_nxt   = 1'b0;
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (state == EMIT) begin
      out_nxt  = a[k];
      ov_nxt   = 1'b1;
      done_nxt = (k == K_LAST);
      err_nxt  = (b[0] == 8'h00);
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r  <= '0;
      ov_r   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      out_r  <= out_nxt;
      ov_r   <= ov_nxt;
      done_r <= done_nxt;
      err_r  <= err_nxt;
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = ov_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_deconvol.sv
// Directed bench for deconvol: frames with hand-computed results, gaps, noise and resets.
module tb_deconvol;

  typedef logic [7:0] y_t [10];
  typedef logic [7:0] b_t [5];
  typedef logic [7:0] a_t [6];

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  deconvol_if bus ();

  deconvol #(.m(6), .n(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  y_t y1   = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd20, 8'd18, 8'd15, 8'd11, 8'd6};
  y_t y2   = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
  b_t b1   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
  b_t b2   = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
  b_t bz   = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
  a_t a16  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
  a_t aff  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_frame(input y_t ys, input b_t bs, input a_t ea, input bit eerr,
                           input bit gap, input bit noise, input bit abort);
    int edges;
    bit seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.Y = ys[i];
      bus.B = (i < 5) ? bs[i] : 8'($urandom);
      if (gap && i < 9) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.Y = 8'($urandom);
        bus.B = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.in_valid = noise;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (noise) begin
        bus.Y = 8'($urandom);
        bus.B = 8'($urandom);
      end
      seen = (bus.out_valid === 1'b1);
    end
    check("latency", edges, 73);
    if (!seen) begin
      bus.in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (noise) begin
          bus.Y = 8'($urandom);
          bus.B = 8'($urandom);
        end
      end
      check($sformatf("out[%0d]", i), bus.out, ea[i]);
      check($sformatf("out_valid[%0d]", i), bus.out_valid, 1);
      check($sformatf("done[%0d]", i), bus.done, (i == 5) ? 1 : 0);
      check($sformatf("err[%0d]", i), bus.err, eerr);
      if (abort) begin
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", bus.out, 0);
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_done", bus.done, 0);
        @(negedge clk) rst = 1'b1;
        return;
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_valid", bus.out_valid, 0);
    check("post_done", bus.done, 0);
    check("post_err", bus.err, 0);
    check("post_out_hold", bus.out, ea[5]);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.Y = '0;
    bus.B = '0;
    rst = 1'b0;
    #1;
    check("rst_out", bus.out, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_frame(y1, b1, a16, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(y2, b2, a16, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(y1, bz, aff, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(y1, b1, a16, 1'b0, 1'b1, 1'b0, 1'b0);

    // partial frame discarded by reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.Y = 8'hA5;
      bus.B = 8'h3C;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check("midload_rst_valid", bus.out_valid, 0);
    @(negedge clk) rst = 1'b1;
    run_frame(y1, b1, a16, 1'b0, 1'b0, 1'b0, 1'b0);

    // in_valid held high with noise while busy, then a clean frame
    run_frame(y1, b1, a16, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(y2, b2, a16, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset during EMIT, then a fresh frame
    run_frame(y1, b1, a16, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(y2, b2, a16, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
